// File: rtl/weight_fetch_arbiter_pkg.sv
// Shared definitions for the weight fetch path: FSM states, slot count and
// the weight RAM address field layout {layer, unit, slot}.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam int SLOTS_PER_UNIT = 4;
  localparam int SLOT_W         = 2;
  localparam int UNIT_W         = 2;
  localparam int LAYER_W        = 2;

  // Address field bit positions within the 6-bit weight address
  localparam int SLOT_LSB     = 0;
  localparam int UNIT_LSB     = SLOT_LSB + SLOT_W;
  localparam int LAYER_LSB    = UNIT_LSB + UNIT_W;
  localparam int ADDR_FIELD_W = LAYER_LSB + LAYER_W;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS_PER_UNIT - 1);

  // Pack layer/unit/slot into the native address field
  function automatic logic [ADDR_FIELD_W-1:0] weight_addr(
    input logic [LAYER_W-1:0] layer,
    input logic [UNIT_W-1:0]  unit,
    input logic [SLOT_W-1:0]  slot
  );
    logic [ADDR_FIELD_W-1:0] a;
    a = '0;
    a[LAYER_LSB +: LAYER_W] = layer;
    a[UNIT_LSB  +: UNIT_W]  = unit;
    a[SLOT_LSB  +: SLOT_W]  = slot;
    return a;
  endfunction

endpackage

// File: rtl/weight_fetch_arbiter_if.sv
// Request / RAM / slot-write bundle between the unit array, the weight RAM
// and the arbiter. The master side is the system (units + RAM), the slave
// side is the arbiter.
interface weight_fetch_arbiter_if
  import nn_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int WEIGHT_W  = 8,
  parameter int ADDR_W    = 8
);
  logic [LAYER_W-1:0]   layer;
  logic [NUM_UNITS-1:0] req;
  logic [NUM_UNITS-1:0] grant;
  logic                 busy;
  logic                 ram_en;
  logic [ADDR_W-1:0]    ram_addr;
  logic [WEIGHT_W-1:0]  ram_data;
  logic [WEIGHT_W-1:0]  weight;
  logic [SLOT_W-1:0]    unit_address;
  logic [NUM_UNITS-1:0] write;
  logic [NUM_UNITS-1:0] set_done;

  modport master (
    output layer, req, ram_data,
    input  grant, busy, ram_en, ram_addr, weight, unit_address, write, set_done
  );

  modport slave (
    input  layer, req, ram_data,
    output grant, busy, ram_en, ram_addr, weight, unit_address, write, set_done
  );
endinterface

// File: rtl/weight_fetch_arbiter_rr_arbiter.sv
// Round-robin select: first requesting unit above the pointer, with wrap.
// The pointer moves to the winner when the grant is taken.
module rr_arbiter #(
  parameter int NUM_UNITS = 4,
  parameter int IDX_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_UNITS-1:0] req,
  input  logic                 take,
  output logic                 win_vld,
  output logic [IDX_W-1:0]     win_idx
);
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;

  // Rotate-priority search starting at ptr+1
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 1; i <= NUM_UNITS; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_UNITS);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Pointer resets to the last unit so unit 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ptr <= IDX_W'(NUM_UNITS - 1);
    else if (take) ptr <= win_idx;
  end
endmodule

// File: rtl/weight_fetch_arbiter.sv
// Weight RAM arbiter: grants one unit at a time, issues its four slot reads,
// and steers the returned weights into that unit's slots.
module weight_fetch_arbiter
  import nn_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int WEIGHT_W  = 8,
  parameter int ADDR_W    = 8,
  parameter int RAM_LAT   = 1
) (
  input  logic clk,
  input  logic reset,
  weight_fetch_arbiter_if.slave bus
);
  localparam int PIPE_MSB = RAM_LAT - 1;
  localparam int DRAIN_W  = $clog2(RAM_LAT + 1);
  localparam logic [DRAIN_W-1:0]   DRAIN_LAST = DRAIN_W'(RAM_LAT);
  localparam logic [NUM_UNITS-1:0] UNIT_ONE   = NUM_UNITS'(1);

  fetch_state_e         state;
  logic [UNIT_W-1:0]    unit_idx;
  logic [LAYER_W-1:0]   layer_q;
  logic [SLOT_W-1:0]    slot_q;
  logic [DRAIN_W-1:0]   drain_cnt;

  logic [NUM_UNITS-1:0] grant_q;
  logic                 busy_q;
  logic                 ram_en_q;
  logic [ADDR_W-1:0]    ram_addr_q;

  // Return path: read-enable and slot delayed until the data is valid
  logic [PIPE_MSB:0]              vld_pipe;
  logic [PIPE_MSB:0][SLOT_W-1:0]  slot_pipe;
  logic [WEIGHT_W-1:0]            weight_q;
  logic [SLOT_W-1:0]              ua_q;
  logic [NUM_UNITS-1:0]           write_q;
  logic [NUM_UNITS-1:0]           set_done_q;

  logic              win_vld;
  logic [UNIT_W-1:0] win_idx;
  logic              take;

  assign take = (state == IDLE) && win_vld;

  rr_arbiter #(
    .NUM_UNITS (NUM_UNITS),
    .IDX_W     (UNIT_W)
  ) u_rr (
    .clk     (clk),
    .rst_n   (reset),
    .req     (bus.req),
    .take    (take),
    .win_vld (win_vld),
    .win_idx (win_idx)
  );

  // Grant FSM and address generator; layer is frozen at grant time
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      unit_idx   <= '0;
      layer_q    <= '0;
      slot_q     <= '0;
      drain_cnt  <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            state      <= FETCH;
            unit_idx   <= win_idx;
            layer_q    <= bus.layer;
            slot_q     <= '0;
            grant_q    <= UNIT_ONE << win_idx;
            busy_q     <= 1'b1;
            ram_en_q   <= 1'b1;
            ram_addr_q <= ADDR_W'(weight_addr(bus.layer, win_idx, '0));
          end
        end
        FETCH: begin
          if (slot_q == SLOT_LAST) begin
            state      <= DRAIN;
            drain_cnt  <= '0;
            ram_en_q   <= 1'b0;
            ram_addr_q <= '0;
          end else begin
            slot_q     <= slot_q + 1'b1;
            ram_addr_q <= ADDR_W'(weight_addr(layer_q, unit_idx, slot_q + 1'b1));
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state   <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Delay line and slot write; a reset drops any in-flight write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe   <= '0;
      slot_pipe  <= '0;
      weight_q   <= '0;
      ua_q       <= '0;
      write_q    <= '0;
      set_done_q <= '0;
    end else begin
      vld_pipe[0]  <= ram_en_q;
      slot_pipe[0] <= slot_q;
      for (int k = 1; k <= PIPE_MSB; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        slot_pipe[k] <= slot_pipe[k-1];
      end
      write_q    <= vld_pipe[PIPE_MSB] ? (UNIT_ONE << unit_idx) : '0;
      set_done_q <= (vld_pipe[PIPE_MSB] && slot_pipe[PIPE_MSB] == SLOT_LAST)
                    ? (UNIT_ONE << unit_idx) : '0;
      if (vld_pipe[PIPE_MSB]) begin
        weight_q <= bus.ram_data;
        ua_q     <= slot_pipe[PIPE_MSB];
      end
    end
  end

  assign bus.grant        = grant_q;
  assign bus.busy         = busy_q;
  assign bus.ram_en       = ram_en_q;
  assign bus.ram_addr     = ram_addr_q;
  assign bus.weight       = weight_q;
  assign bus.unit_address = ua_q;
  assign bus.write        = write_q;
  assign bus.set_done     = set_done_q;
endmodule

// File: tb/tb_weight_fetch_arbiter.sv
// Directed bench for weight_fetch_arbiter with a synchronous RAM model
// whose word at address a is a ^ 8'h5A.
module tb_weight_fetch_arbiter;
  import nn_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  weight_fetch_arbiter_if #(.NUM_UNITS(4), .WEIGHT_W(8), .ADDR_W(8)) bus ();

  weight_fetch_arbiter #(
    .NUM_UNITS (4),
    .WEIGHT_W  (8),
    .ADDR_W    (8),
    .RAM_LAT   (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Weight RAM, one-cycle synchronous read
  always @(posedge clk) begin
    if (bus.ram_en) bus.ram_data <= bus.ram_addr ^ 8'h5A;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check one observed cycle; addr only when reading, slot/weight only when writing
  task automatic exp_cyc(input string tag, input logic [3:0] g, input logic b,
                         input logic en, input logic [7:0] addr, input logic [3:0] wr,
                         input logic [1:0] ua, input logic [7:0] w, input logic [3:0] sd);
    chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
    chk({tag, ".ram_en"}, 32'(bus.ram_en), 32'(en));
    if (en) chk({tag, ".ram_addr"}, 32'(bus.ram_addr), 32'(addr));
    chk({tag, ".write"}, 32'(bus.write), 32'(wr));
    if (wr != 4'b0) begin
      chk({tag, ".unit_address"}, 32'(bus.unit_address), 32'(ua));
      chk({tag, ".weight"}, 32'(bus.weight), 32'(w));
    end
    chk({tag, ".set_done"}, 32'(bus.set_done), 32'(sd));
  endtask

  // Wait (bounded) for the next rising grant and check its owner
  task automatic next_grant(input string tag, input logic [3:0] exp);
    int n;
    n = 0;
    while (bus.grant !== 4'b0 && n < 20) begin @(negedge clk); n++; end
    while (bus.grant === 4'b0 && n < 40) begin @(negedge clk); n++; end
    chk(tag, 32'(bus.grant), 32'(exp));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    chk(tag, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int p, k;
    logic [7:0] a;
    reset        = 1'b1;
    bus.req      = 4'b1111;
    bus.layer    = 2'd0;
    bus.ram_data = 8'h00;
    #2 reset = 1'b0;

    // Reset: everything held at zero despite requests
    repeat (3) @(negedge clk);
    exp_cyc("rst", 4'b0, 1'b0, 1'b0, 8'h00, 4'b0, 2'd0, 8'h00, 4'b0);
    chk("rst.ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst.weight", 32'(bus.weight), 32'd0);
    chk("rst.unit_address", 32'(bus.unit_address), 32'd0);

    // All request: units 0..3 in order, 7 cycles each, units drop req on set_done
    reset = 1'b1;
    for (int c = 1; c <= 28; c++) begin
      @(negedge clk);
      p = (c - 1) % 7;
      k = (c - 1) / 7;
      a = 8'(k * 4 + p - 2);
      exp_cyc($sformatf("all.c%0d", c),
              (p < 6) ? 4'(1 << k) : 4'b0, p < 6, p < 4, 8'(k * 4 + p),
              (p >= 2 && p <= 5) ? 4'(1 << k) : 4'b0, 2'(p - 2), a ^ 8'h5A,
              (p == 5) ? 4'(1 << k) : 4'b0);
      bus.req = bus.req & ~bus.set_done;
    end

    // Fairness: 0 and 3 keep requesting -> alternate; then 1 and 2 join
    bus.req = 4'b1001;
    next_grant("fair.g0", 4'b0001);
    next_grant("fair.g1", 4'b1000);
    next_grant("fair.g2", 4'b0001);
    next_grant("fair.g3", 4'b1000);
    bus.req = 4'b1111;
    next_grant("fair.g4", 4'b0001);
    next_grant("fair.g5", 4'b0010);
    next_grant("fair.g6", 4'b0100);
    bus.req = 4'b0000;
    wait_idle("fair.idle");

    // Single fetch: unit 2, layer 1
    bus.req   = 4'b0100;
    bus.layer = 2'd1;
    @(negedge clk); exp_cyc("sf.t1", 4'b0100, 1, 1, 8'h18, 4'b0,    2'd0, 8'h00, 4'b0);
    @(negedge clk); exp_cyc("sf.t2", 4'b0100, 1, 1, 8'h19, 4'b0,    2'd0, 8'h00, 4'b0);
    @(negedge clk); exp_cyc("sf.t3", 4'b0100, 1, 1, 8'h1A, 4'b0100, 2'd0, 8'h42, 4'b0);
    @(negedge clk); exp_cyc("sf.t4", 4'b0100, 1, 1, 8'h1B, 4'b0100, 2'd1, 8'h43, 4'b0);
    @(negedge clk); exp_cyc("sf.t5", 4'b0100, 1, 0, 8'h00, 4'b0100, 2'd2, 8'h40, 4'b0);
    @(negedge clk); exp_cyc("sf.t6", 4'b0100, 1, 0, 8'h00, 4'b0100, 2'd3, 8'h41, 4'b0100);
    bus.req = 4'b0000;
    @(negedge clk); exp_cyc("sf.t7", 4'b0,    0, 0, 8'h00, 4'b0,    2'd0, 8'h00, 4'b0);

    // Layer change at T2 is ignored: unit 1 stays on layer 1
    bus.req   = 4'b0010;
    bus.layer = 2'd1;
    @(negedge clk); exp_cyc("lc.t1", 4'b0010, 1, 1, 8'h14, 4'b0,    2'd0, 8'h00, 4'b0);
    @(negedge clk); exp_cyc("lc.t2", 4'b0010, 1, 1, 8'h15, 4'b0,    2'd0, 8'h00, 4'b0);
    bus.layer = 2'd2;
    @(negedge clk); exp_cyc("lc.t3", 4'b0010, 1, 1, 8'h16, 4'b0010, 2'd0, 8'h4E, 4'b0);
    @(negedge clk); exp_cyc("lc.t4", 4'b0010, 1, 1, 8'h17, 4'b0010, 2'd1, 8'h4F, 4'b0);
    @(negedge clk); exp_cyc("lc.t5", 4'b0010, 1, 0, 8'h00, 4'b0010, 2'd2, 8'h4C, 4'b0);
    @(negedge clk); exp_cyc("lc.t6", 4'b0010, 1, 0, 8'h00, 4'b0010, 2'd3, 8'h4D, 4'b0010);
    bus.req = 4'b0000;
    @(negedge clk); exp_cyc("lc.t7", 4'b0,    0, 0, 8'h00, 4'b0,    2'd0, 8'h00, 4'b0);

    // Reset mid-fetch: unit 1 granted (pointer=1), reset at T3
    bus.req   = 4'b0010;
    bus.layer = 2'd0;
    @(negedge clk); exp_cyc("rm.t1", 4'b0010, 1, 1, 8'h04, 4'b0,    2'd0, 8'h00, 4'b0);
    @(negedge clk); exp_cyc("rm.t2", 4'b0010, 1, 1, 8'h05, 4'b0,    2'd0, 8'h00, 4'b0);
    @(negedge clk); exp_cyc("rm.t3", 4'b0010, 1, 1, 8'h06, 4'b0010, 2'd0, 8'h5E, 4'b0);
    reset = 1'b0;
    #1;
    exp_cyc("rm.async", 4'b0, 0, 0, 8'h00, 4'b0, 2'd0, 8'h00, 4'b0);
    // Pointer back to 3: unit 0 beats unit 3 even though unit 1 was last
    bus.req = 4'b1011;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); exp_cyc("rm.regrant", 4'b0001, 1, 1, 8'h00, 4'b0, 2'd0, 8'h00, 4'b0);
    bus.req = 4'b0000;
    wait_idle("rm.idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/weight_fetch_arbiter.md
# weight_fetch_arbiter

Shares the single-port weight RAM among the four neural units. Each unit requests its weight set for the current layer; the arbiter grants one unit at a time in round-robin order. It generates the four RAM addresses for that unit and steers the returned weights, slot by slot, into the unit's weight slots. It sits between the network-level layer controller (source of `layer`) and the neural-unit array, in place of a fixed unit-by-unit read sequence.

## Interface
Parameters:
- `NUM_UNITS`, 4, number of requesting neural units
- `WEIGHT_W`, 8, weight width
- `ADDR_W`, 8, weight RAM address width; must be ≥ 6
- `RAM_LAT`, 1, weight RAM read latency in cycles (synchronous read)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `layer`  in  2  current layer index; sampled at grant
- `req`  in  NUM_UNITS  per-unit weight-set request, level
- `grant`  out  NUM_UNITS  one-hot, owner of the current fetch
- `busy`  out  1  fetch in progress
- `ram_en`  out  1  weight RAM read enable
- `ram_addr`  out  ADDR_W  weight RAM read address
- `ram_data`  in  WEIGHT_W  weight RAM read data, valid RAM_LAT cycles after `ram_en`
- `weight`  out  WEIGHT_W  weight to the units (shared bus)
- `unit_address`  out  2  weight slot index 0..3
- `write`  out  NUM_UNITS  one-hot slot write strobe
- `set_done`  out  NUM_UNITS  one-cycle pulse: granted unit's four weights are written

## Operation
- All outputs are registered. In reset, every output is 0, the FSM is in IDLE and the round-robin pointer is NUM_UNITS-1, so unit 0 has highest priority first.
- FSM states: IDLE, FETCH, DRAIN.
  - **IDLE:** if `req` ≠ 0, pick the winner as the first set bit searching from pointer+1 upward, with wrap. Latch the winner index and `layer`. Set pointer to the winner and go to FETCH. If `req` = 0, stay in IDLE.
  - **FETCH:** 4 cycles. `ram_en`=1 and `ram_addr` = zero-extend({layer_latched, unit_idx, slot}), slot 0..3. Then go to DRAIN.
  - **DRAIN:** RAM_LAT+1 cycles, while the last reads return. Then go to IDLE.
- Return path:
  - `ram_data` is captured into `weight` one cycle after it is valid.
  - `write[unit]` and `unit_address` = slot are driven in the same cycle as `weight`, with the slot delayed to match.
- `set_done[unit]` pulses in the cycle of the slot-3 write.
- `grant` and `busy` are high from the first FETCH cycle through the last DRAIN cycle.
- Request rules:
  - A unit holds `req` until it sees `set_done`.
  - A unit drops `req` on the edge where it samples `set_done`=1.
  - A `req` still high in IDLE is a new request.
  - Dropping `req` mid-fetch does not abort the fetch; it completes and `set_done` still pulses.
- A `layer` change during FETCH or DRAIN has no effect. The latched value is used for all four addresses.
- Asserting `reset` mid-fetch clears everything immediately. A pending slot write is lost, and the unit re-requests after reset.

## Timing
- T0 = IDLE cycle in which `req` is seen. `grant`, `busy`, `ram_en` rise at T1.
- Addresses for slots 0..3 at T1..T4.
- With RAM_LAT=1: data valid at T2..T5, writes at T3..T6, `set_done` at T6.
- `grant` and `busy` fall at T7, which is also the next IDLE cycle. The next grant can be active at T8.
- Occupancy per grant: 1 + 4 + RAM_LAT + 1 cycles, i.e. 7 cycles at RAM_LAT=1.
- Only one `write` bit is ever set. `write` is zero outside T3..T6.

## Structure
- Shared package `nn_pkg` holds:
  - the FSM state enum (IDLE/FETCH/DRAIN)
  - slots-per-unit = 4
  - the address field layout (layer, unit, slot bit positions)
- One sub-module, `rr_arbiter`: combinational rotate-priority select from `req` and pointer, plus the registered pointer update on grant.
- The FSM, address generator and return-path delay line live in `weight_fetch_arbiter`.

## Test plan
- **Reset:** drive `reset`=0 with `req`=4'b1111 → all outputs 0 and no `ram_en`. After release, unit 0 is granted first.
- **Single fetch:** `req`=4'b0100, `layer`=1, RAM returns A0..A3 → `ram_addr` 0x18..0x1B at T1..T4; `write`=4'b0100 with `unit_address` 0..3 and `weight` A0..A3 at T3..T6; `set_done`[2] at T6.
- **All request:** `req`=4'b1111 from reset → grants in order 0,1,2,3, 7 cycles each, with no overlap of `write` bits.
- **Fairness:** units 0 and 3 re-raise `req` immediately after each `set_done` → grants alternate 0,3,0,3. Units 1 and 2, if requesting, get their turn in pointer order.
- **Layer change mid-fetch:** `layer` changes 1→2 at T2 for unit 1 → addresses 0x14..0x17 throughout.
- **Reset mid-fetch:** reset asserted at T3 → `grant`, `write`, `ram_en` are 0 in the same cycle. After release, the pointer restarts at unit 0.
